// File: rtl/universal_ff_bank.sv
// WIDTH-bit bank of flip-flops with runtime SR/JK/D/T mode select and sticky SR illegal-input tracking.
// Optional macro UFF_ERR_CNT_EN adds the saturating ERR_CNT illegal-cycle counter and its port.
module universal_ff_bank #(
    parameter int unsigned           WIDTH     = 8,
    parameter logic [WIDTH-1:0]      RESET_VAL = '0,
    parameter int unsigned           CNT_W     = 8
) (
    input  logic             clk,
    input  logic             CLR,
    input  logic             SET,
    input  logic             EN,
    input  logic [1:0]       MODE,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             ERR_CLR,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Q_not,
    output logic             ERR,
`ifdef UFF_ERR_CNT_EN
    output logic [WIDTH-1:0] ERR_BITS,
    output logic [CNT_W-1:0] ERR_CNT
`else
    output logic [WIDTH-1:0] ERR_BITS
`endif
);

    typedef enum logic [1:0] {
        MODE_SR = 2'b00,
        MODE_JK = 2'b01,
        MODE_D  = 2'b10,
        MODE_T  = 2'b11
    } mode_e;

    mode_e            w_mode;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_illegal;
    logic             w_any_illegal;

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_q_not;
    logic             r_err;
    logic [WIDTH-1:0] r_err_bits;

    assign w_mode = mode_e'(MODE);

    always_comb begin
        w_next = r_q;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            unique case (w_mode)
                MODE_SR: begin
                    // SR 11 holds rather than going undefined
                    case ({A[i], B[i]})
                        2'b01:   w_next[i] = 1'b0;
                        2'b10:   w_next[i] = 1'b1;
                        default: w_next[i] = r_q[i];
                    endcase
                end
                MODE_JK: begin
                    case ({A[i], B[i]})
                        2'b01:   w_next[i] = 1'b0;
                        2'b10:   w_next[i] = 1'b1;
                        2'b11:   w_next[i] = ~r_q[i];
                        default: w_next[i] = r_q[i];
                    endcase
                end
                MODE_D:  w_next[i] = A[i];
                MODE_T:  w_next[i] = r_q[i] ^ A[i];
                default: w_next[i] = r_q[i];
            endcase
        end
    end

    always_comb begin
        w_illegal = '0;
        if ((w_mode == MODE_SR) && EN && SET) begin
            w_illegal = A & B;
        end
        w_any_illegal = |w_illegal;
    end

    always_ff @(posedge clk) begin
        if (!CLR) begin
            r_q        <= RESET_VAL;
            r_q_not    <= ~RESET_VAL;
            r_err      <= 1'b0;
            r_err_bits <= '0;
        end else begin
            if (!SET) begin
                r_q     <= '1;
                r_q_not <= '0;
            end else if (EN) begin
                r_q     <= w_next;
                r_q_not <= ~w_next;
            end
            // a new illegal event on the same edge as ERR_CLR replaces the old record
            if (w_any_illegal) begin
                r_err      <= 1'b1;
                r_err_bits <= ERR_CLR ? w_illegal : (r_err_bits | w_illegal);
            end else if (ERR_CLR) begin
                r_err      <= 1'b0;
                r_err_bits <= '0;
            end
        end
    end

`ifdef UFF_ERR_CNT_EN
    logic [CNT_W-1:0] r_err_cnt;

    always_ff @(posedge clk) begin
        if (!CLR) begin
            r_err_cnt <= '0;
        end else if (w_any_illegal) begin
            if (ERR_CLR) begin
                r_err_cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
            end else if (r_err_cnt != '1) begin
                r_err_cnt <= r_err_cnt + 1'b1;
            end
        end else if (ERR_CLR) begin
            r_err_cnt <= '0;
        end
    end

    assign ERR_CNT = r_err_cnt;
`endif

    assign Q        = r_q;
    assign Q_not    = r_q_not;
    assign ERR      = r_err;
    assign ERR_BITS = r_err_bits;

endmodule

// File: tb/tb_universal_ff_bank.sv
// Scoreboard bench for universal_ff_bank (WIDTH=8, RESET_VAL=8'h5A, CNT_W=8); checks ERR_CNT when UFF_ERR_CNT_EN is defined.
module tb_universal_ff_bank;

    logic       clk;
    logic       CLR, SET, EN, ERR_CLR;
    logic [1:0] MODE;
    logic [7:0] A, B;
    logic [7:0] Q, Q_not, ERR_BITS;
    logic       ERR;
`ifdef UFF_ERR_CNT_EN
    logic [7:0] ERR_CNT;
`endif

    universal_ff_bank #(
        .WIDTH     (8),
        .RESET_VAL (8'h5A),
        .CNT_W     (8)
    ) dut (
        .clk      (clk),
        .CLR      (CLR),
        .SET      (SET),
        .EN       (EN),
        .MODE     (MODE),
        .A        (A),
        .B        (B),
        .ERR_CLR  (ERR_CLR),
        .Q        (Q),
        .Q_not    (Q_not),
        .ERR      (ERR),
`ifdef UFF_ERR_CNT_EN
        .ERR_BITS (ERR_BITS),
        .ERR_CNT  (ERR_CNT)
`else
        .ERR_BITS (ERR_BITS)
`endif
    );

    typedef struct {
        logic [7:0] q;
        logic       err;
        logic [7:0] bits;
        logic [7:0] cnt;
    } exp_t;

    exp_t       sb[$];
    int         n_checks = 0;
    int         n_fail   = 0;

    logic [7:0] m_q, m_bits, m_cnt;
    logic       m_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic cl, input logic st, input logic en, input logic [1:0] md,
                         input logic [7:0] a, input logic [7:0] b, input logic ec);
        logic [7:0] ill;
        if (!cl) begin
            m_q = 8'h5A; m_err = 1'b0; m_bits = '0; m_cnt = '0;
        end else begin
            ill = (st && en && md == 2'b00) ? (a & b) : 8'h00;
            if (!st) m_q = 8'hFF;
            else if (en) begin
                for (int i = 0; i < 8; i++) begin
                    case (md)
                        2'b00: if (a[i] != b[i]) m_q[i] = a[i];
                        2'b01: if (a[i] && b[i]) m_q[i] = ~m_q[i];
                               else if (a[i] != b[i]) m_q[i] = a[i];
                        2'b10: m_q[i] = a[i];
                        default: m_q[i] = m_q[i] ^ a[i];
                    endcase
                end
            end
            if (ill != 8'h00) begin
                m_err  = 1'b1;
                m_bits = ec ? ill : (m_bits | ill);
                m_cnt  = ec ? 8'd1 : ((m_cnt == 8'hFF) ? 8'hFF : m_cnt + 8'd1);
            end else if (ec) begin
                m_err = 1'b0; m_bits = '0; m_cnt = '0;
            end
        end
    endtask

    // Drives one cycle at the falling edge, records the expectation, compares at the next falling edge
    task automatic step(input logic cl, input logic st, input logic en, input logic [1:0] md,
                        input logic [7:0] a, input logic [7:0] b, input logic ec);
        exp_t e;
        CLR = cl; SET = st; EN = en; MODE = md; A = a; B = b; ERR_CLR = ec;
        model(cl, st, en, md, a, b, ec);
        e.q = m_q; e.err = m_err; e.bits = m_bits; e.cnt = m_cnt;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk("q", {24'd0, Q}, {24'd0, e.q});
            chk("q_not", {24'd0, Q_not}, {24'd0, ~e.q});
            chk("err", {31'd0, ERR}, {31'd0, e.err});
            chk("err_bits", {24'd0, ERR_BITS}, {24'd0, e.bits});
`ifdef UFF_ERR_CNT_EN
            chk("err_cnt", {24'd0, ERR_CNT}, {24'd0, e.cnt});
`endif
        end
    endtask

    initial begin
        CLR = 1'b0; SET = 1'b0; EN = 1'b1; MODE = 2'b00; A = '0; B = '0; ERR_CLR = 1'b0;
        m_q = '0; m_err = 1'b0; m_bits = '0; m_cnt = '0;
        @(negedge clk);

        step(1'b0, 1'b0, 1'b1, 2'b00, 8'h00, 8'h00, 1'b0);
        step(1'b0, 1'b0, 1'b1, 2'b00, 8'h00, 8'h00, 1'b0);
        chk("rst_q", {24'd0, Q}, 32'h5A);
        chk("rst_qn", {24'd0, Q_not}, 32'hA5);
        chk("rst_err", {31'd0, ERR}, 32'd0);

        step(1'b1, 1'b0, 1'b1, 2'b00, 8'h00, 8'h00, 1'b0);
        chk("preset_q", {24'd0, Q}, 32'hFF);
        chk("preset_qn", {24'd0, Q_not}, 32'h00);

        step(1'b1, 1'b1, 1'b1, 2'b10, 8'h3C, 8'h00, 1'b0);
        chk("d_q", {24'd0, Q}, 32'h3C);

        step(1'b1, 1'b1, 1'b1, 2'b11, 8'h0F, 8'h00, 1'b0);
        chk("t1", {24'd0, Q}, 32'h33);
        step(1'b1, 1'b1, 1'b1, 2'b11, 8'h0F, 8'h00, 1'b0);
        chk("t2", {24'd0, Q}, 32'h3C);
        step(1'b1, 1'b1, 1'b1, 2'b11, 8'h0F, 8'h00, 1'b0);
        chk("t3", {24'd0, Q}, 32'h33);
        step(1'b1, 1'b1, 1'b0, 2'b11, 8'hFF, 8'h00, 1'b0);
        chk("hold", {24'd0, Q}, 32'h33);

        step(1'b1, 1'b1, 1'b1, 2'b01, 8'hF0, 8'h0F, 1'b0);
        chk("jk1", {24'd0, Q}, 32'hF0);
        step(1'b1, 1'b1, 1'b1, 2'b01, 8'hFF, 8'hFF, 1'b0);
        chk("jk_toggle", {24'd0, Q}, 32'h0F);
        chk("jk_err", {31'd0, ERR}, 32'd0);

        step(1'b1, 1'b1, 1'b1, 2'b00, 8'h81, 8'h01, 1'b0);
        chk("sr_q", {24'd0, Q}, 32'h8F);
        chk("sr_err", {31'd0, ERR}, 32'd1);
        chk("sr_bits", {24'd0, ERR_BITS}, 32'h01);
`ifdef UFF_ERR_CNT_EN
        chk("sr_cnt", {24'd0, ERR_CNT}, 32'd1);
`endif
        for (int i = 0; i < 300; i++) step(1'b1, 1'b1, 1'b1, 2'b00, 8'h81, 8'h01, 1'b0);
`ifdef UFF_ERR_CNT_EN
        chk("cnt_sat", {24'd0, ERR_CNT}, 32'd255);
`endif

        step(1'b1, 1'b1, 1'b1, 2'b00, 8'h02, 8'h02, 1'b1);
        chk("clr_new_bits", {24'd0, ERR_BITS}, 32'h02);
        chk("clr_new_err", {31'd0, ERR}, 32'd1);
`ifdef UFF_ERR_CNT_EN
        chk("clr_new_cnt", {24'd0, ERR_CNT}, 32'd1);
`endif
        step(1'b1, 1'b1, 1'b1, 2'b00, 8'h00, 8'h00, 1'b1);
        chk("clr_err", {31'd0, ERR}, 32'd0);
        chk("clr_bits", {24'd0, ERR_BITS}, 32'h00);

        for (int i = 0; i < 200; i++) begin
            step(($urandom_range(0, 15) != 0), ($urandom_range(0, 7) != 0),
                 ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                 8'($urandom), 8'($urandom), ($urandom_range(0, 7) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
